// File: rtl/vblank_update_scheduler.sv
// vblank_update_scheduler
//
// Grants the shared game-state update slot to one object updater at a time during vertical
// blanking, so pixel_gen never sees state change during active video. At each vblank entry the
// per-frame served mask is cleared. Eligible requesters (req & ~served) are then granted
// round-robin. Each grant ends on done[g], or on timeout. If active video restarts while a grant
// is still held, the grant is aborted.
//
// Ports:
//   clk_50MHz   in   system clock
//   reset_n     in   asynchronous active-low reset
//   p_tick      in   pixel-clock enable; y is only sampled when high
//   y           in   current line from the VGA controller
//   req         in   level request per updater
//   done        in   completion pulse per updater (only done[g] of the owner counts)
//   grant       out  one-hot owner of the update slot, or zero
//   frame_start out  one-cycle pulse at vblank entry
//   busy        out  high from frame_start until the frame's work is finished or aborted
//   frame_cnt   out  number of frames seen, wraps
//   timeout_err out  one-cycle pulse in the last cycle of a forced release
//   overrun     out  sticky; a grant was still held when active video restarted
module vblank_update_scheduler #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned VBLANK_LINE = 480,
    parameter int unsigned LAST_LINE   = 524,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic            clk_50MHz,
    input  logic            reset_n,
    input  logic            p_tick,
    input  logic [9:0]      y,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] done,
    output logic [NREQ-1:0] grant,
    output logic            frame_start,
    output logic            busy,
    output logic [7:0]      frame_cnt,
    output logic            timeout_err,
    output logic            overrun
);

    localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic [9:0]      VbY        = 10'(VBLANK_LINE);
    localparam logic [9:0]      LastY      = 10'(LAST_LINE);
    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);
    localparam logic [PtrW-1:0] LastIdx    = PtrW'(NREQ - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StScan  = 2'd1;
    localparam logic [1:0] StGrant = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [PtrW-1:0] g_q, g_d;
    logic [PtrW-1:0] rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0] served_q, served_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            overrun_q, overrun_d;

    logic            in_vb_q;
    logic            in_vb_prev_q;
    logic            armed_q;
    logic            frame_start_q;
    logic [7:0]      frame_cnt_q;

    logic            y_in_vb;
    logic            vb_rise;
    logic [PtrW:0]   scan_res;

    // Lines outside the frame never count as blanking.
    assign y_in_vb = (y >= VbY) && (y <= LastY);

    // armed_q requires a non-blanking line to be seen after reset, so releasing reset in the
    // middle of vblank does not start a frame until the next genuine vblank entry.
    assign vb_rise = in_vb_q & ~in_vb_prev_q & armed_q;

    // Returns {found, index} of the first set bit of elig, searching upward from start with
    // wrap-around.
    function automatic logic [PtrW:0] pick_next(input logic [NREQ-1:0] elig,
                                                input logic [PtrW-1:0] start);
        logic [PtrW:0]   res;
        logic [PtrW-1:0] idx;
        res = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = PtrW'((32'(start) + k) % NREQ);
            if (!res[PtrW] && elig[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    assign scan_res = pick_next(req & ~served_q, rr_ptr_q);

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            in_vb_q       <= 1'b0;
            in_vb_prev_q  <= 1'b0;
            armed_q       <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
        end else begin
            if (p_tick) begin
                in_vb_q <= y_in_vb;
                if (!y_in_vb) begin
                    armed_q <= 1'b1;
                end
            end
            in_vb_prev_q  <= in_vb_q;
            frame_start_q <= vb_rise;
            if (vb_rise) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        g_d       = g_q;
        rr_ptr_d  = rr_ptr_q;
        served_d  = served_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;

        if (frame_start_q) begin
            served_d = '0;
        end

        case (state_q)
            StIdle: begin
                if (frame_start_q) begin
                    state_d = StScan;
                end
            end
            StScan: begin
                if (!in_vb_q) begin
                    state_d = StIdle;
                end else if (scan_res[PtrW]) begin
                    g_d     = scan_res[PtrW-1:0];
                    cnt_d   = '0;
                    state_d = StGrant;
                end else begin
                    state_d = StIdle;
                end
            end
            StGrant: begin
                // Abort wins over done/timeout; rr_ptr is left alone so the aborted owner is
                // first in line next frame.
                if (!in_vb_q) begin
                    overrun_d = 1'b1;
                    state_d   = StIdle;
                end else if (done[g_q] || (cnt_q == TimeoutCnt)) begin
                    served_d[g_q] = 1'b1;
                    rr_ptr_d      = (g_q == LastIdx) ? '0 : g_q + PtrW'(1);
                    state_d       = StScan;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            g_q       <= '0;
            rr_ptr_q  <= '0;
            served_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            g_q       <= g_d;
            rr_ptr_q  <= rr_ptr_d;
            served_q  <= served_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign grant       = (state_q == StGrant) ? (NREQ'(1) << g_q) : '0;
    assign frame_start = frame_start_q;
    assign busy        = frame_start_q | (state_q != StIdle);
    assign frame_cnt   = frame_cnt_q;
    assign timeout_err = (state_q == StGrant) && in_vb_q && (cnt_q == TimeoutCnt);
    assign overrun     = overrun_q;

endmodule
